// File: rtl/tag_ram_ctrl.sv
// Tag RAM controller: flushes (invalidates) every entry after reset or on request,
// and arbitrates lookups and refills for a single-port tag RAM in round-robin order.
module tag_ram_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req_i,
    output logic                  flush_ack_o,
    output logic                  busy_o,
    input  logic                  lkp_req_i,
    input  logic [ADDR_WIDTH-1:0] lkp_addr_i,
    input  logic [TAG_WIDTH-1:0]  lkp_tag_i,
    output logic                  lkp_gnt_o,
    output logic                  lkp_rvalid_o,
    output logic                  lkp_hit_o,
    output logic [TAG_WIDTH:0]    lkp_rdata_o,
    input  logic                  rfl_req_i,
    input  logic [ADDR_WIDTH-1:0] rfl_addr_i,
    input  logic [TAG_WIDTH-1:0]  rfl_tag_i,
    output logic                  rfl_gnt_o,
    output logic                  tag_req_o,
    output logic                  tag_write_o,
    output logic [ADDR_WIDTH-1:0] tag_addr_o,
    output logic [TAG_WIDTH:0]    tag_wdata_o,
    input  logic [TAG_WIDTH:0]    tag_rdata_i
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = '1;

    typedef enum logic {FLUSH, IDLE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  last_lkp_q, last_lkp_d;
    logic                  pend_q;
    logic [TAG_WIDTH-1:0]  tag_q;

    // Outputs are held quiet while rst is high so the reset values hold from the first cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_lkp_d  = last_lkp_q;
        lkp_gnt_o   = 1'b0;
        rfl_gnt_o   = 1'b0;
        flush_ack_o = 1'b0;
        tag_req_o   = 1'b0;
        tag_write_o = 1'b0;
        tag_addr_o  = '0;
        tag_wdata_o = '0;
        if (!rst) begin
            case (state_q)
                FLUSH: begin
                    tag_req_o   = 1'b1;
                    tag_write_o = 1'b1;
                    tag_addr_o  = cnt_q;
                    if (cnt_q == LAST_ENTRY) begin
                        flush_ack_o = 1'b1;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (flush_req_i) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else if (lkp_req_i && (!rfl_req_i || !last_lkp_q)) begin
                        lkp_gnt_o  = 1'b1;
                        last_lkp_d = 1'b1;
                        tag_req_o  = 1'b1;
                        tag_addr_o = lkp_addr_i;
                    end else if (rfl_req_i) begin
                        rfl_gnt_o   = 1'b1;
                        last_lkp_d  = 1'b0;
                        tag_req_o   = 1'b1;
                        tag_write_o = 1'b1;
                        tag_addr_o  = rfl_addr_i;
                        tag_wdata_o = {1'b1, rfl_tag_i};
                    end
                end
                default: state_d = FLUSH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FLUSH;
            cnt_q      <= '0;
            last_lkp_q <= 1'b0;
            pend_q     <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_lkp_q <= last_lkp_d;
            pend_q     <= lkp_gnt_o;
            if (lkp_gnt_o) begin
                tag_q <= lkp_tag_i;
            end
        end
    end

    assign busy_o       = rst || (state_q == FLUSH);
    assign lkp_rvalid_o = pend_q && !rst;
    assign lkp_rdata_o  = lkp_rvalid_o ? tag_rdata_i : '0;
    assign lkp_hit_o    = lkp_rvalid_o && tag_rdata_i[TAG_WIDTH]
                          && (tag_rdata_i[TAG_WIDTH-1:0] == tag_q);

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Directed bench for tag_ram_ctrl with a behavioural single-port tag RAM attached.
module tb_tag_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_req;
    logic       flush_ack;
    logic       busy;
    logic       lkp_req;
    logic [5:0] lkp_addr;
    logic [5:0] lkp_tag;
    logic       lkp_gnt;
    logic       lkp_rvalid;
    logic       lkp_hit;
    logic [6:0] lkp_rdata;
    logic       rfl_req;
    logic [5:0] rfl_addr;
    logic [5:0] rfl_tag;
    logic       rfl_gnt;
    logic       tag_req;
    logic       tag_write;
    logic [5:0] tag_addr;
    logic [6:0] tag_wdata;
    logic [6:0] tag_rdata;

    logic [6:0] mem [64];
    int n_pass = 0;
    int n_checks = 0;
    int ack_cnt = 0;
    int ack_base;

    tag_ram_ctrl #(.ADDR_WIDTH(6), .TAG_WIDTH(6)) dut (
        .clk(clk), .rst(rst),
        .flush_req_i(flush_req), .flush_ack_o(flush_ack), .busy_o(busy),
        .lkp_req_i(lkp_req), .lkp_addr_i(lkp_addr), .lkp_tag_i(lkp_tag), .lkp_gnt_o(lkp_gnt),
        .lkp_rvalid_o(lkp_rvalid), .lkp_hit_o(lkp_hit), .lkp_rdata_o(lkp_rdata),
        .rfl_req_i(rfl_req), .rfl_addr_i(rfl_addr), .rfl_tag_i(rfl_tag), .rfl_gnt_o(rfl_gnt),
        .tag_req_o(tag_req), .tag_write_o(tag_write), .tag_addr_o(tag_addr),
        .tag_wdata_o(tag_wdata), .tag_rdata_i(tag_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tag_req === 1'b1) begin
            if (tag_write === 1'b1) mem[tag_addr] <= tag_wdata;
            else                    tag_rdata <= mem[tag_addr];
        end
        if (flush_ack === 1'b1) ack_cnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic r, input logic f, input logic lr, input logic [5:0] la,
                                 input logic [5:0] lt, input logic rr, input logic [5:0] ra,
                                 input logic [5:0] rt);
        @(negedge clk);
        rst = r; flush_req = f;
        lkp_req = lr; lkp_addr = la; lkp_tag = lt;
        rfl_req = rr; rfl_addr = ra; rfl_tag = rt;
        #1;
    endtask

    task automatic hold();
        @(negedge clk);
        #1;
    endtask

    task automatic run_flush(input int merge_at);
        for (int i = 0; i < 64; i++) begin
            checkOutput("flush_ctl", {27'd0, tag_req, tag_write, busy, lkp_gnt, rfl_gnt}, 32'b11100);
            checkOutput("flush_addr", {26'd0, tag_addr}, i);
            checkOutput("flush_wdata", {25'd0, tag_wdata}, 32'd0);
            checkOutput("flush_ack", {31'd0, flush_ack}, {31'd0, i == 63});
            flush_req = (i == merge_at);
            if (i == 63) begin
                lkp_req = 1'b0;
                rfl_req = 1'b0;
            end
            hold();
        end
        checkOutput("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // reset state
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd1);
        checkOutput("rst_outs", {27'd0, flush_ack, lkp_gnt, rfl_gnt, lkp_rvalid, lkp_hit}, 32'd0);
        checkOutput("rst_tag_req", {31'd0, tag_req}, 32'd0);

        // initialisation flush: 64 writes, ack on the last one
        ack_base = ack_cnt;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        run_flush(-1);
        checkOutput("init_ack_count", ack_cnt, ack_base + 1);

        // both requesting: lookup, refill, lookup, refill
        applyStimulus(0, 0, 1, 6'd9, 6'h11, 1, 6'd9, 6'h11);
        checkOutput("rr1_gnt", {30'd0, lkp_gnt, rfl_gnt}, 32'b10);
        checkOutput("rr1_ram", {24'd0, tag_req, tag_write, tag_addr}, {24'd0, 2'b10, 6'd9});
        hold();
        checkOutput("rr2_gnt", {30'd0, lkp_gnt, rfl_gnt}, 32'b01);
        checkOutput("rr2_wdata", {25'd0, tag_wdata}, 32'h51);
        checkOutput("rr2_resp", {23'd0, lkp_rvalid, lkp_hit, lkp_rdata}, {23'd0, 2'b10, 7'h00});
        hold();
        checkOutput("rr3_gnt", {30'd0, lkp_gnt, rfl_gnt}, 32'b10);
        checkOutput("rr3_rvalid", {31'd0, lkp_rvalid}, 32'd0);
        hold();
        checkOutput("rr4_gnt", {30'd0, lkp_gnt, rfl_gnt}, 32'b01);
        checkOutput("rr4_resp", {23'd0, lkp_rvalid, lkp_hit, lkp_rdata}, {23'd0, 2'b11, 7'h51});

        // refill addr 5 tag 2A, then back-to-back lookups
        applyStimulus(0, 0, 0, 0, 0, 1, 6'd5, 6'h2A);
        checkOutput("rfl5_gnt", {30'd0, lkp_gnt, rfl_gnt}, 32'b01);
        checkOutput("rfl5_ram", {17'd0, tag_req, tag_write, tag_addr, tag_wdata},
                    {17'd0, 2'b11, 6'd5, 7'h6A});
        applyStimulus(0, 0, 1, 6'd5, 6'h2A, 0, 0, 0);
        checkOutput("lkp5_gnt", {30'd0, lkp_gnt, rfl_gnt}, 32'b10);
        checkOutput("lkp5_ram", {24'd0, tag_req, tag_write, tag_addr}, {24'd0, 2'b10, 6'd5});
        checkOutput("lkp5_no_rvalid", {31'd0, lkp_rvalid}, 32'd0);
        applyStimulus(0, 0, 1, 6'd9, 6'h12, 0, 0, 0);
        checkOutput("lkp9_gnt", {31'd0, lkp_gnt}, 32'd1);
        checkOutput("hit5_resp", {23'd0, lkp_rvalid, lkp_hit, lkp_rdata}, {23'd0, 2'b11, 7'h6A});
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("miss9_resp", {23'd0, lkp_rvalid, lkp_hit, lkp_rdata}, {23'd0, 2'b10, 7'h51});
        checkOutput("idle_ram", {17'd0, tag_req, tag_write, tag_addr, tag_wdata}, 32'd0);
        applyStimulus(0, 0, 1, 6'd5, 6'h2B, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("miss2B_resp", {23'd0, lkp_rvalid, lkp_hit, lkp_rdata}, {23'd0, 2'b10, 7'h6A});
        hold();
        checkOutput("resp_drop", {30'd0, lkp_rvalid, lkp_hit}, 32'd0);

        // flush request wins over both requesters; second request mid-flush is merged
        ack_base = ack_cnt;
        applyStimulus(0, 1, 1, 6'd5, 6'h2A, 1, 6'd7, 6'h3F);
        checkOutput("flreq_gnt", {29'd0, lkp_gnt, rfl_gnt, tag_req}, 32'd0);
        checkOutput("flreq_busy", {31'd0, busy}, 32'd0);
        applyStimulus(0, 0, 1, 6'd5, 6'h2A, 1, 6'd7, 6'h3F);
        run_flush(10);
        checkOutput("merge_ack_count", ack_cnt, ack_base + 1);
        applyStimulus(0, 0, 1, 6'd5, 6'h2A, 0, 0, 0);
        checkOutput("post_flush_gnt", {31'd0, lkp_gnt}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_flush_miss", {23'd0, lkp_rvalid, lkp_hit, lkp_rdata}, {23'd0, 2'b10, 7'h00});
        checkOutput("merge_ack_count2", ack_cnt, ack_base + 1);

        // reset drops a pending lookup response
        applyStimulus(0, 0, 1, 6'd5, 6'h2A, 0, 0, 0);
        checkOutput("pre_rst_gnt", {31'd0, lkp_gnt}, 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_drop_resp", {30'd0, lkp_rvalid, lkp_hit}, 32'd0);
        checkOutput("rst_drop_busy", {31'd0, busy}, 32'd1);

        // reset at flush counter 30 restarts from entry 0 without acking the aborted flush
        ack_base = ack_cnt;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 30; i++) begin
            checkOutput("abort_addr", {26'd0, tag_addr}, i);
            if (i < 30) hold();
        end
        rst = 1'b1;
        #1;
        checkOutput("abort_rst_outs", {29'd0, busy, flush_ack, tag_req}, 32'b100);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        run_flush(-1);
        checkOutput("abort_ack_count", ack_cnt, ack_base + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tag_ram_ctrl.md
TAG_RAM_CTRL -- requirements
Module: tag_ram_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 6, meaning tag RAM index width (NumEntries = 2**ADDR_WIDTH).
REQ-002 The module SHALL have parameter TAG_WIDTH, default 6, meaning stored tag width; RAM word = TAG_WIDTH+1 bits, MSB = valid.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port flush_req_i, input, 1 bit: request invalidation of all entries.
REQ-006 The module SHALL have port flush_ack_o, output, 1 bit: one-cycle pulse when a flush completes.
REQ-007 The module SHALL have port busy_o, output, 1 bit: high while a flush is in progress.
REQ-008 The module SHALL have ports lkp_req_i (in, 1), lkp_addr_i (in, ADDR_WIDTH), lkp_tag_i (in, TAG_WIDTH), lkp_gnt_o (out, 1): lookup request channel.
REQ-009 The module SHALL have ports lkp_rvalid_o (out, 1), lkp_hit_o (out, 1), lkp_rdata_o (out, TAG_WIDTH+1): lookup response.
REQ-010 The module SHALL have ports rfl_req_i (in, 1), rfl_addr_i (in, ADDR_WIDTH), rfl_tag_i (in, TAG_WIDTH), rfl_gnt_o (out, 1): refill write channel.
REQ-011 The module SHALL have ports tag_req_o (out, 1), tag_write_o (out, 1), tag_addr_o (out, ADDR_WIDTH), tag_wdata_o (out, TAG_WIDTH+1), tag_rdata_i (in, TAG_WIDTH+1): single-port tag RAM, read data valid one cycle after a read request.

Function
REQ-012 The FSM SHALL have states FLUSH and IDLE; FLUSH owns the RAM exclusively, lookup and refill grants are 0 there.
REQ-013 In FLUSH the module SHALL issue one write per cycle: tag_req_o=1, tag_write_o=1, tag_addr_o=flush counter, tag_wdata_o=0.
REQ-014 The flush counter SHALL increment by 1 per cycle; on writing entry NumEntries-1 the FSM SHALL go to IDLE, pulse flush_ack_o for that one cycle, and clear the counter to 0.
REQ-015 flush_req_i seen in IDLE SHALL enter FLUSH next cycle with counter 0; flush_req_i during FLUSH SHALL be merged (no restart, single ack).
REQ-016 In IDLE, flush_req_i SHALL take priority: no lookup/refill grant is issued in the cycle flush_req_i is high.
REQ-017 In IDLE, grants SHALL be combinational same-cycle; at most one of lkp_gnt_o/rfl_gnt_o is high per cycle.
REQ-018 Lookup vs refill arbitration SHALL be round-robin on a last-grant bit: when both request, the one not granted most recently wins; lone requester always wins.
REQ-019 A refill grant SHALL drive tag_req_o=1, tag_write_o=1, tag_addr_o=rfl_addr_i, tag_wdata_o={1'b1, rfl_tag_i}.
REQ-020 A lookup grant SHALL drive tag_req_o=1, tag_write_o=0, tag_addr_o=lkp_addr_i, and register lkp_tag_i.
REQ-021 lkp_rvalid_o SHALL be high exactly one cycle after each lookup grant; lkp_rdata_o=tag_rdata_i; lkp_hit_o = tag_rdata_i[MSB] AND tag_rdata_i[TAG_WIDTH-1:0]==registered tag; both 0 when lkp_rvalid_o=0.
REQ-022 Back-to-back lookup grants SHALL be supported, one response per cycle, in order.
REQ-023 A lookup granted in the cycle before entering FLUSH SHALL still return its response in the first FLUSH cycle.
REQ-024 With no grant and not flushing, tag_req_o SHALL be 0 and tag_write_o, tag_addr_o, tag_wdata_o SHALL be 0.

Reset
REQ-025 While rst=1 the FSM SHALL be forced to FLUSH with counter 0, last-grant bit = refill, pending lookup response cleared.
REQ-026 Reset values SHALL be: busy_o=1, flush_ack_o=0, lkp_gnt_o=0, rfl_gnt_o=0, lkp_rvalid_o=0, lkp_hit_o=0; after rst falls a full NumEntries-cycle initialisation flush SHALL run and end with flush_ack_o.
REQ-027 Reset asserted mid-flush SHALL restart the flush from entry 0; reset during a pending lookup response SHALL drop it (no rvalid).

Verification
REQ-028 Release reset, ADDR_WIDTH=6 -> 64 consecutive writes of 0 to addr 0..63, flush_ack_o on cycle 64 with addr 63, busy_o falls next cycle.
REQ-029 Refill addr 5 tag 0x2A, then lookup addr 5 tag 0x2A -> lkp_rvalid_o one cycle after grant, lkp_rdata_o=0x6A, lkp_hit_o=1; lookup tag 0x2B -> hit=0.
REQ-030 lkp_req_i and rfl_req_i held high together 4 cycles after reset flush -> grants alternate lookup, refill, lookup, refill.
REQ-031 flush_req_i pulsed in IDLE with both requests high, then again at flush counter 10 -> no grants for 64 cycles, one flush_ack_o only, prior refill addr 5 then misses.
REQ-032 rst asserted at flush counter 30 for 1 cycle -> flush restarts at addr 0, total 64 writes before flush_ack_o, no ack for the aborted flush.
